regfile_loader: RTL and testbench

//  Host-side writer for the 32x128 accelerator register file. Accepts a burst of
//  32-bit words over a valid/ready stream, packs each 4 words into one 128-bit

---
 rtl/crypto_pkg.sv | 10 +
 rtl/regfile_loader_if.sv | 24 ++
 rtl/regfile_loader_word_packer.sv | 25 ++
 rtl/regfile_loader.sv | 75 +++++++
 tb/tb_regfile_loader.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/crypto_pkg.sv
// crypto_pkg: constants and state type shared by the register-file loader
package crypto_pkg;
    localparam int DATA_W = 128;
    localparam int WORD_W = 32;
    localparam int REG_IDX_W = 5;
    localparam int WORDS_PER_REG = DATA_W / WORD_W;
    localparam int CNT_W = $clog2(WORDS_PER_REG);
    localparam logic [REG_IDX_W-1:0] ZERO_REG = 5'd31;
    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} loader_state_t;
endpackage

// File: rtl/regfile_loader_if.sv
// regfile_loader_if: host control, word stream and register-file write port of the loader
interface regfile_loader_if;
    import crypto_pkg::*;
    logic start;
    logic [REG_IDX_W-1:0] base_reg;
    logic [REG_IDX_W:0] num_regs;
    logic in_valid;
    logic [WORD_W-1:0] in_data;
    logic in_ready;
    logic [REG_IDX_W-1:0] WriteReg;
    logic [DATA_W-1:0] WriteData;
    logic WriteEnable;
    logic busy;
    logic done;
    logic error;
    modport master (
        output start, base_reg, num_regs, in_valid, in_data,
        input in_ready, WriteReg, WriteData, WriteEnable, busy, done, error
    );
    modport slave (
        input start, base_reg, num_regs, in_valid, in_data,
        output in_ready, WriteReg, WriteData, WriteEnable, busy, done, error
    );
endinterface

// File: rtl/regfile_loader_word_packer.sv
// regfile_loader_word_packer: shifts stream words into one register-wide value, first word on top
module regfile_loader_word_packer
    import crypto_pkg::*;
(
    input logic clk,
    input logic reset,
    input logic push,
    input logic [WORD_W-1:0] word,
    output logic [DATA_W-1:0] packed_data,
    output logic full
);
    logic [DATA_W-WORD_W-1:0] buffer;
    logic [CNT_W-1:0] cnt;
    assign packed_data = {buffer, word};
    assign full = push && &cnt;
    always_ff @(posedge clk) begin
        if (reset) begin
            buffer <= '0;
            cnt <= '0;
        end else if (push) begin
            buffer <= packed_data[DATA_W-WORD_W-1:0];
            cnt <= cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/regfile_loader.sv
// regfile_loader: packs a 32-bit word stream into 128-bit writes to consecutive registers
module regfile_loader
    import crypto_pkg::*;
(
    input logic clk,
    input logic reset,
    regfile_loader_if.slave bus
);
    loader_state_t state;
    logic [REG_IDX_W-1:0] target;
    logic [REG_IDX_W-1:0] remaining;
    logic [REG_IDX_W:0] last_reg;
    logic [DATA_W-1:0] packed_data;
    logic full;
    assign bus.in_ready = state == LOAD;
    assign last_reg = {1'b0, bus.base_reg} + bus.num_regs - 6'd1;
    regfile_loader_word_packer packer (
        .clk(clk),
        .reset(reset),
        .push(bus.in_valid && bus.in_ready),
        .word(bus.in_data),
        .packed_data(packed_data),
        .full(full)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            target <= '0;
            remaining <= '0;
            bus.WriteReg <= '0;
            bus.WriteData <= '0;
            bus.WriteEnable <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.error <= 1'b0;
        end else begin
            bus.WriteEnable <= 1'b0;
            bus.done <= 1'b0;
            bus.error <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    if (bus.num_regs == '0) begin
                        state <= DONE;
                        bus.busy <= 1'b1;
                        bus.done <= 1'b1;
                    // counts above 31 could wrap the 6-bit end index, so they never pass
                    end else if (bus.num_regs[REG_IDX_W] || last_reg >= {1'b0, ZERO_REG}) begin
                        bus.error <= 1'b1;
                    end else begin
                        state <= LOAD;
                        bus.busy <= 1'b1;
                        target <= bus.base_reg;
                        remaining <= bus.num_regs[REG_IDX_W-1:0];
                    end
                end
                LOAD: if (full) begin
                    state <= WRITE;
                    bus.WriteEnable <= 1'b1;
                    bus.WriteReg <= target;
                    bus.WriteData <= packed_data;
                end
                WRITE: begin
                    target <= target + REG_IDX_W'(1);
                    remaining <= remaining - REG_IDX_W'(1);
                    state <= remaining == REG_IDX_W'(1) ? DONE : LOAD;
                    bus.done <= remaining == REG_IDX_W'(1);
                end
                default: begin
                    state <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_loader.sv
// tb_regfile_loader: table, hand-written and random bursts checked against a register-file model
module tb_regfile_loader;
    import crypto_pkg::*;

    typedef struct {
        int base;
        int num;
        logic [31:0] fw;
        int gap_at;
        int gap_len;
        bit poke;
        int exp_err;
        int exp_done;
        int exp_wr;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    regfile_loader_if bus();
    regfile_loader dut (.clk(clk), .reset(reset), .bus(bus));

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int viol = 0;
    int done_cyc = 0;
    logic [DATA_W-1:0] rf [32] = '{default: '0};
    logic [DATA_W-1:0] mref [32];
    logic [WORD_W-1:0] wq[$];
    int log_reg[$];
    logic [DATA_W-1:0] log_data[$];
    int log_cyc[$];
    vec_t tbl [10];

    always @(posedge clk) cyc <= cyc + 1;

    // stands in for the register file and records every write pulse
    always @(negedge clk) begin
        if (bus.done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (bus.error) err_cnt <= err_cnt + 1;
        if (bus.WriteEnable) begin
            rf[bus.WriteReg] <= bus.WriteData;
            log_reg.push_back(int'(bus.WriteReg));
            log_data.push_back(bus.WriteData);
            log_cyc.push_back(cyc);
            if (bus.in_ready || bus.WriteReg == ZERO_REG) viol <= viol + 1;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chkd(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_done"}, int'(bus.done), 0);
        chk({tag, "_error"}, int'(bus.error), 0);
        chk({tag, "_we"}, int'(bus.WriteEnable), 0);
        chk({tag, "_in_ready"}, int'(bus.in_ready), 0);
        chk({tag, "_wreg"}, int'(bus.WriteReg), 0);
        chkd({tag, "_wdata"}, bus.WriteData, '0);
    endtask

    task automatic run_burst(input int b, input int n, input bit rnd, input logic [31:0] fw,
                             input int gap_at, input int gap_len, input bit poke, input int vprob,
                             input int exp_err, input int exp_done, input int exp_wr);
        int idx, g, t, d0, e0, v0, nbad;
        bit legal, stall;
        int exp_reg[$];
        logic [DATA_W-1:0] exp_data[$];
        legal = n != 0 && b + n - 1 < 31;
        wq.delete();
        log_reg.delete();
        log_data.delete();
        log_cyc.delete();
        for (int i = 0; i < 4 * n; i++) wq.push_back(rnd ? $urandom : fw * 32'(i + 1));
        if (legal)
            for (int r = 0; r < n; r++) begin
                exp_reg.push_back(b + r);
                exp_data.push_back({wq[4*r], wq[4*r+1], wq[4*r+2], wq[4*r+3]});
                mref[b + r] = exp_data[r];
            end
        d0 = done_cnt;
        e0 = err_cnt;
        v0 = viol;
        idx = 0;
        g = 0;
        t = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.base_reg = 5'(b);
        bus.num_regs = 6'(n);
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_after_start", int'(bus.busy), int'(exp_err == 0));
        while (done_cnt == d0 && err_cnt == e0 && t < 600) begin
            bus.start = poke && t == 2;
            if (bus.start) begin
                bus.base_reg = 5'd10;
                bus.num_regs = 6'd1;
            end
            stall = idx == gap_at && g < gap_len;
            if (stall) g++;
            stall = stall || int'($urandom_range(99)) >= vprob;
            bus.in_valid = idx < wq.size() && !stall;
            if (bus.in_valid) bus.in_data = wq[idx];
            if (bus.in_valid && bus.in_ready) idx++;
            @(negedge clk);
            t++;
        end
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        chk("burst_timeout", int'(t < 600), 1);
        repeat (3) @(negedge clk);
        chk("error_pulses", err_cnt - e0, exp_err);
        chk("done_pulses", done_cnt - d0, exp_done);
        chk("write_count", log_reg.size(), exp_wr);
        chk("words_consumed", idx, legal ? 4 * n : 0);
        chk("write_violations", viol - v0, 0);
        chk("busy_after_burst", int'(bus.busy), 0);
        for (int i = 0; i < log_reg.size() && i < exp_reg.size(); i++) begin
            chk("write_reg", log_reg[i], exp_reg[i]);
            chkd("write_data", log_data[i], exp_data[i]);
        end
        if (exp_reg.size() > 0 && log_reg.size() > 0) begin
            chk("done_latency", done_cyc - log_cyc[log_reg.size() - 1], 1);
            chk("hold_reg", int'(bus.WriteReg), exp_reg[$]);
            chkd("hold_data", bus.WriteData, exp_data[$]);
        end
        if (gap_at < 0 && vprob >= 100 && !poke)
            for (int i = 1; i < log_cyc.size(); i++) chk("write_interval", log_cyc[i] - log_cyc[i-1], 5);
        nbad = 0;
        for (int r = 0; r < 32; r++) if (rf[r] !== mref[r]) nbad++;
        chk("regfile_contents", nbad, 0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int r = 0; r < 32; r++) mref[r] = '0;
        bus.start = 1'b0;
        bus.base_reg = '0;
        bus.num_regs = '0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        tbl[0] = '{5, 1, 32'h11111111, -1, 0, 1'b0, 0, 1, 1};
        tbl[1] = '{0, 3, 32'h01020304, -1, 0, 1'b0, 0, 1, 3};
        tbl[2] = '{30, 1, 32'h30303001, -1, 0, 1'b0, 0, 1, 1};
        tbl[3] = '{30, 2, 32'h30303002, -1, 0, 1'b0, 1, 0, 0};
        tbl[4] = '{0, 0, 32'h00000000, -1, 0, 1'b0, 0, 1, 0};
        tbl[5] = '{9, 2, 32'hA5A50001, 2, 3, 1'b0, 0, 1, 2};
        tbl[6] = '{2, 2, 32'h22220001, -1, 0, 1'b1, 0, 1, 2};
        tbl[7] = '{31, 1, 32'h31313101, -1, 0, 1'b0, 1, 0, 0};
        tbl[8] = '{20, 11, 32'h20200001, -1, 0, 1'b0, 0, 1, 11};
        tbl[9] = '{21, 11, 32'h21210001, -1, 0, 1'b0, 1, 0, 0};
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 10; i++)
            run_burst(tbl[i].base, tbl[i].num, 1'b0, tbl[i].fw, tbl[i].gap_at, tbl[i].gap_len,
                      tbl[i].poke, 100, tbl[i].exp_err, tbl[i].exp_done, tbl[i].exp_wr);
        chkd("reg5_value", rf[5], 128'h11111111_22222222_33333333_44444444);
        run_burst(7, 1, 1'b0, 32'h70000001, -1, 0, 1'b0, 100, 0, 1, 1);
        log_reg.delete();
        @(negedge clk);
        bus.start = 1'b1;
        bus.base_reg = 5'd7;
        bus.num_regs = 6'd1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = 32'hDEAD0001;
        @(negedge clk);
        bus.in_data = 32'hDEAD0002;
        @(negedge clk);
        bus.in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check_zero("mid_reset");
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_reset_writes", log_reg.size(), 0);
        chkd("mid_reset_reg7", rf[7], mref[7]);
        run_burst(7, 1, 1'b0, 32'h0BAD0001, -1, 0, 1'b0, 100, 0, 1, 1);
        for (int k = 0; k < 25; k++) begin
            int b, n;
            bit lg;
            b = int'($urandom_range(31));
            n = int'($urandom_range(6));
            lg = n != 0 && b + n - 1 < 31;
            run_burst(b, n, 1'b1, '0, -1, 0, 1'b0, 60 + int'($urandom_range(40)),
                      int'(n != 0 && !lg), int'(n == 0 || lg), lg ? n : 0);
        end
        chkd("reg31_zero", rf[31], '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
